// File: rtl/board_state.sv
// Battleship player state: fleet and attack maps, cursor control,
// turn sequencing and shot/result exchange with the radio link.
module board_state #(
    parameter int SHIP_CELLS = 5,
    parameter int BLINK_BIT  = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btnUp,
    input  logic            btnDown,
    input  logic            btnLeft,
    input  logic            btnRight,
    input  logic            btnFire,
    input  logic            goFirst,
    output logic            txValid,
    output logic [5:0]      txCoord,
    input  logic            txReady,
    input  logic            rxResultValid,
    input  logic            rxHit,
    input  logic            rxShotValid,
    input  logic [5:0]      rxCoord,
    output logic            txResultValid,
    output logic            txHit,
    output logic [2:0]      state,
    output logic [7:0][7:0] redArray,
    output logic [7:0][7:0] greenArray
);

    typedef enum logic [2:0] {
        PLACE       = 3'd0,
        AIM         = 3'd1,
        WAIT_RESULT = 3'd2,
        DEFEND      = 3'd3,
        WON         = 3'd4,
        LOST        = 3'd5
    } state_e;

    localparam logic [6:0] SHIPS = 7'(SHIP_CELLS);

    state_e           state_q, state_d;
    logic [2:0]       row_q, row_d, col_q, col_d;
    logic [63:0]      ship_q, ship_d, hit_q, hit_d, miss_q, miss_d;
    logic [6:0]       placed_q, placed_d;
    logic [6:0]       made_q, made_d, taken_q, taken_d;
    logic [BLINK_BIT:0] blink_q;
    logic             tx_valid_q, tx_valid_d;
    logic [5:0]       tx_coord_q, tx_coord_d;
    logic             tx_res_q, tx_res_d;
    logic             tx_hit_q, tx_hit_d;

    logic [5:0]  cur;
    logic [63:0] cur_mask, shot_mask, rx_mask;
    logic        btn_en, blink;
    logic [63:0] green_v, red_v;

    assign cur       = {row_q, col_q};
    assign cur_mask  = 64'd1 << cur;
    assign shot_mask = 64'd1 << tx_coord_q;
    assign rx_mask   = 64'd1 << rxCoord;
    assign blink     = blink_q[BLINK_BIT];
    // Buttons are frozen while an outgoing shot waits for the link.
    assign btn_en    = (state_q == PLACE) ||
                       (state_q == AIM && !tx_valid_q);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        ship_d     = ship_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        placed_d   = placed_q;
        made_d     = made_q;
        taken_d    = taken_q;
        tx_valid_d = tx_valid_q;
        tx_coord_d = tx_coord_q;
        tx_res_d   = 1'b0;
        tx_hit_d   = tx_hit_q;

        if (btn_en) begin
            priority case (1'b1)
                btnUp:    row_d = row_q - 3'd1;
                btnDown:  row_d = row_q + 3'd1;
                btnLeft:  col_d = col_q - 3'd1;
                btnRight: col_d = col_q + 3'd1;
                btnFire: begin
                    if (state_q == PLACE) begin
                        if (!ship_q[cur]) begin
                            ship_d   = ship_q | cur_mask;
                            placed_d = placed_q + 7'd1;
                            if (placed_q + 7'd1 == SHIPS)
                                state_d = goFirst ? AIM : DEFEND;
                        end
                    end else if (!(hit_q[cur] | miss_q[cur])) begin
                        tx_valid_d = 1'b1;
                        tx_coord_d = cur;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            AIM: begin
                if (tx_valid_q && txReady) begin
                    tx_valid_d = 1'b0;
                    state_d    = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (rxResultValid) begin
                    if (rxHit) begin
                        hit_d  = hit_q | shot_mask;
                        made_d = made_q + 7'd1;
                        state_d = (made_q + 7'd1 == SHIPS) ? WON : DEFEND;
                    end else begin
                        miss_d  = miss_q | shot_mask;
                        state_d = DEFEND;
                    end
                end
            end
            DEFEND: begin
                if (rxShotValid) begin
                    tx_res_d = 1'b1;
                    tx_hit_d = ship_q[rxCoord];
                    state_d  = AIM;
                    if (ship_q[rxCoord]) begin
                        ship_d  = ship_q & ~rx_mask;
                        taken_d = taken_q + 7'd1;
                        if (taken_q + 7'd1 == SHIPS)
                            state_d = LOST;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PLACE;
            row_q      <= '0;
            col_q      <= '0;
            ship_q     <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            placed_q   <= '0;
            made_q     <= '0;
            taken_q    <= '0;
            blink_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_coord_q <= '0;
            tx_res_q   <= 1'b0;
            tx_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ship_q     <= ship_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            placed_q   <= placed_d;
            made_q     <= made_d;
            taken_q    <= taken_d;
            blink_q    <= blink_q + {{BLINK_BIT{1'b0}}, 1'b1};
            tx_valid_q <= tx_valid_d;
            tx_coord_q <= tx_coord_d;
            tx_res_q   <= tx_res_d;
            tx_hit_q   <= tx_hit_d;
        end
    end

    always_comb begin
        green_v = ship_q;
        red_v   = hit_q | (miss_q & {64{blink}});
        case (state_q)
            PLACE: if (blink) green_v = ship_q ^ cur_mask;
            AIM:   red_v = (red_v & ~cur_mask) | (blink ? cur_mask : 64'd0);
            WON:   red_v = '1;
            LOST: begin
                green_v = '0;
                red_v   = {64{blink}};
            end
            default: ;
        endcase
    end

    assign greenArray    = green_v;
    assign redArray      = red_v;
    assign state         = state_q;
    assign txValid       = tx_valid_q;
    assign txCoord       = tx_coord_q;
    assign txResultValid = tx_res_q;
    assign txHit         = tx_hit_q;

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state: vector table for placement/cursor, scoreboarded
// shot and answer traffic, plus hand sequences for turns, win, loss, reset.
module tb_board_state;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, btnUp, btnDown, btnLeft, btnRight, btnFire, goFirst;
    logic txValid, txReady, rxResultValid, rxHit, rxShotValid;
    logic txResultValid, txHit;
    logic [5:0] txCoord, rxCoord;
    logic [2:0] state;
    logic [7:0][7:0] redArray, greenArray;
    logic [63:0] g64, r64;

    board_state #(.SHIP_CELLS(2), .BLINK_BIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft),
        .btnRight(btnRight), .btnFire(btnFire), .goFirst(goFirst),
        .txValid(txValid), .txCoord(txCoord), .txReady(txReady),
        .rxResultValid(rxResultValid), .rxHit(rxHit),
        .rxShotValid(rxShotValid), .rxCoord(rxCoord),
        .txResultValid(txResultValid), .txHit(txHit), .state(state),
        .redArray(redArray), .greenArray(greenArray)
    );

    assign g64 = greenArray;
    assign r64 = redArray;

    int checks = 0;
    int failures = 0;
    int tv_cnt = 0;
    logic [5:0] exp_tx[$];
    logic exp_rsp[$];

    typedef struct {
        int          act;
        logic        go;
        logic [2:0]  st;
        logic [5:0]  cur;
        logic [63:0] ship;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (txValid) tv_cnt++;
        if (txValid && txReady) begin
            if (exp_tx.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_unexpected: got %0h expected none", txCoord);
            end else chk("tx_coord_sb", 64'(txCoord), 64'(exp_tx.pop_front()));
        end
        if (txResultValid) begin
            if (exp_rsp.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_unexpected: got %0b expected none", txHit);
            end else chk("rsp_hit_sb", 64'(txHit), 64'(exp_rsp.pop_front()));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // 1 up, 2 down, 3 left, 4 right, 5 fire
    task automatic press(input int a);
        btnUp = (a == 1); btnDown = (a == 2); btnLeft = (a == 3);
        btnRight = (a == 4); btnFire = (a == 5);
        step();
        btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0; btnFire = 0;
    endtask

    task automatic fire_aim(input logic [5:0] c);
        exp_tx.push_back(c);
        press(5);
    endtask

    task automatic result(input logic h);
        rxResultValid = 1; rxHit = h;
        step();
        rxResultValid = 0; rxHit = 0;
    endtask

    task automatic shot(input logic [5:0] c, input logic e);
        exp_rsp.push_back(e);
        rxShotValid = 1; rxCoord = c;
        step();
        rxShotValid = 0; rxCoord = 0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        step(); step();
        rst_n = 1;
    endtask

    task automatic blink_count(input bit use_red, input int idx, output int n);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(use_red ? r64[idx] : g64[idx]);
            step();
        end
    endtask

    task automatic run_vec(input int i);
        logic [63:0] m;
        goFirst = v[i].go;
        press(v[i].act);
        goFirst = 0;
        m = ~(64'd1 << v[i].cur);
        chk($sformatf("vec%0d_state", i), 64'(state), 64'(v[i].st));
        chk($sformatf("vec%0d_green", i), g64 & m, v[i].ship & m);
    endtask

    initial begin
        int n, n0, ones, zeros;
        rst_n = 0; btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0;
        btnFire = 0; goFirst = 0; txReady = 0; rxResultValid = 0;
        rxHit = 0; rxShotValid = 0; rxCoord = 0;

        for (int i = 0; i < 9; i++)
            v[i] = '{3, 1'b0, 3'd0, {3'd0, 3'((64 - (i + 1)) % 8)}, 64'd0};
        v[9]  = '{4, 1'b0, 3'd0, 6'd0, 64'd0};
        v[10] = '{5, 1'b0, 3'd0, 6'd0, 64'h1};
        v[11] = '{5, 1'b0, 3'd0, 6'd0, 64'h1};
        v[12] = '{4, 1'b0, 3'd0, 6'd1, 64'h1};
        v[13] = '{5, 1'b1, 3'd1, 6'd1, 64'h3};

        step(); step();
        rst_n = 1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_txValid", 64'(txValid), 64'd0);
        chk("rst_txCoord", 64'(txCoord), 64'd0);
        chk("rst_txResultValid", 64'(txResultValid), 64'd0);
        chk("rst_txHit", 64'(txHit), 64'd0);
        chk("rst_red", r64, 64'd0);
        chk("rst_green", g64 & ~64'd1, 64'd0);

        for (int i = 0; i < 9; i++) run_vec(i);
        blink_count(0, 7, n);
        chk("cursor_0_7_blink", 64'(n), 64'd4);
        for (int i = 9; i < 14; i++) run_vec(i);
        chk("aim_green", g64, 64'h3);

        press(2); press(2); press(2);
        press(4); press(4); press(4); press(4);
        exp_tx.push_back(6'b011101);
        n0 = tv_cnt;
        press(5);
        chk("aim_txValid", 64'(txValid), 64'd1);
        chk("aim_txCoord", 64'(txCoord), 64'b011101);
        press(3);
        step(); step(); step();
        chk("stall_txValid", 64'(txValid), 64'd1);
        txReady = 1;
        step();
        txReady = 0;
        chk("xfer_txValid", 64'(txValid), 64'd0);
        chk("xfer_state", 64'(state), 64'd2);
        chk("txValid_cycles", 64'(tv_cnt - n0), 64'd5);

        result(0);
        chk("miss_state", 64'(state), 64'd3);
        blink_count(1, 29, n);
        chk("miss_blink", 64'(n), 64'd4);

        shot(6'b000001, 1);
        chk("def_valid", 64'(txResultValid), 64'd1);
        chk("def_hit", 64'(txHit), 64'd1);
        chk("def_green01", 64'(g64[1]), 64'd0);
        chk("def_state", 64'(state), 64'd1);
        step();
        chk("def_pulse_end", 64'(txResultValid), 64'd0);

        press(5);
        chk("refire_none", 64'(txValid), 64'd0);
        step();
        chk("refire_none2", 64'(txValid), 64'd0);

        press(3);
        txReady = 1;
        fire_aim(6'b011100);
        step();
        txReady = 0;
        chk("shot2_state", 64'(state), 64'd2);
        result(1);
        chk("hit_state", 64'(state), 64'd3);
        chk("hit_red", 64'(r64[28]), 64'd1);
        result(1);
        chk("stray_result", 64'(state), 64'd3);

        shot(6'b000001, 0);
        chk("repeat_valid", 64'(txResultValid), 64'd1);
        chk("repeat_miss", 64'(txHit), 64'd0);
        chk("repeat_state", 64'(state), 64'd1);

        press(3);
        txReady = 1;
        fire_aim(6'b011011);
        step();
        txReady = 0;
        result(0);
        chk("shot3_state", 64'(state), 64'd3);
        shot(6'b000000, 1);
        chk("lost_state", 64'(state), 64'd5);
        chk("lost_green", g64, 64'd0);
        ones = 0; zeros = 0;
        for (int i = 0; i < 8; i++) begin
            if (r64 == '1) ones++;
            if (r64 == '0) zeros++;
            step();
        end
        chk("lost_red_ones", 64'(ones), 64'd4);
        chk("lost_red_whole", 64'(ones + zeros), 64'd8);

        do_reset();
        chk("rst2_state", 64'(state), 64'd0);
        press(5); press(4);
        press(5);
        chk("gofirst0_state", 64'(state), 64'd3);
        shot(6'd63, 0);
        chk("won_def1", 64'(state), 64'd1);
        txReady = 1;
        fire_aim(6'd1);
        step();
        txReady = 0;
        result(1);
        chk("won_hit1", 64'(state), 64'd3);
        shot(6'd63, 0);
        press(4);
        txReady = 1;
        fire_aim(6'd2);
        step();
        txReady = 0;
        result(1);
        chk("won_state", 64'(state), 64'd4);
        chk("won_red", r64, '1);
        chk("won_green", g64, 64'h3);

        do_reset();
        press(5); press(4);
        goFirst = 1;
        press(5);
        goFirst = 0;
        chk("rst3_aim", 64'(state), 64'd1);
        press(5);
        chk("rst3_txValid", 64'(txValid), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("async_txValid", 64'(txValid), 64'd0);
        chk("async_state", 64'(state), 64'd0);
        step();
        rst_n = 1;
        step();

        chk("sb_tx_empty", 64'(exp_tx.size()), 64'd0);
        chk("sb_rsp_empty", 64'(exp_rsp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
